bram32_arbiter: RTL and testbench

- Shares the single bram32 data memory between the instruction-fetch port (I, read-only, word) and the load/store port (D, byte/half/word).
- Sits between the core and bram32.
- Grants at most one access per cycle using round-robin.
- Guarantees r_enb and w_enb are never both asserted. Generates byte_enb and write-lane alignment for stores; extracts and extends load data.
- Returns every response registered, exactly one cycle after acceptance.

---
 rtl/bram32_arbiter_if.sv | 41 ++++
 rtl/bram32_arbiter.sv | 101 ++++++++++
 tb/tb_bram32_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/bram32_arbiter_if.sv
// bram32_arbiter_if: fetch port, load/store port and bram32 memory port of the arbiter
interface bram32_arbiter_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) ();
    logic                    i_valid;
    logic                    i_ready;
    logic [ADDR_WIDTH-1:0]   i_addr;
    logic                    i_rvalid;
    logic [DATA_WIDTH-1:0]   i_rdata;
    logic                    i_err;
    logic                    d_valid;
    logic                    d_ready;
    logic                    d_we;
    logic [1:0]              d_size;
    logic                    d_unsigned;
    logic [ADDR_WIDTH-1:0]   d_addr;
    logic [DATA_WIDTH-1:0]   d_wdata;
    logic                    d_rvalid;
    logic [DATA_WIDTH-1:0]   d_rdata;
    logic                    d_err;
    logic [ADDR_WIDTH-1:0]   mem_w_addr;
    logic [DATA_WIDTH-1:0]   mem_w_dat;
    logic                    mem_w_enb;
    logic [DATA_WIDTH/8-1:0] mem_byte_enb;
    logic [ADDR_WIDTH-1:0]   mem_r_addr;
    logic                    mem_r_enb;
    logic [DATA_WIDTH-1:0]   mem_r_dat;

    modport slave (
        input  i_valid, i_addr, d_valid, d_we, d_size, d_unsigned, d_addr, d_wdata, mem_r_dat,
        output i_ready, i_rvalid, i_rdata, i_err, d_ready, d_rvalid, d_rdata, d_err,
               mem_w_addr, mem_w_dat, mem_w_enb, mem_byte_enb, mem_r_addr, mem_r_enb
    );

    modport master (
        output i_valid, i_addr, d_valid, d_we, d_size, d_unsigned, d_addr, d_wdata, mem_r_dat,
        input  i_ready, i_rvalid, i_rdata, i_err, d_ready, d_rvalid, d_rdata, d_err,
               mem_w_addr, mem_w_dat, mem_w_enb, mem_byte_enb, mem_r_addr, mem_r_enb
    );
endinterface

// File: rtl/bram32_arbiter.sv
// bram32_arbiter: round-robin sharing of one bram32 between instruction fetch and load/store
module bram32_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    bram32_arbiter_if.slave  bus
);
    logic                  r_last_d;
    logic                  r_i_rvalid;
    logic                  r_i_err;
    logic [DATA_WIDTH-1:0] r_i_rdata;
    logic                  r_d_rvalid;
    logic                  r_d_err;
    logic [DATA_WIDTH-1:0] r_d_rdata;

    logic                  w_gnt_i;
    logic                  w_gnt_d;
    logic                  w_i_err;
    logic                  w_d_err;
    logic                  w_d_load;
    logic                  w_d_store;
    logic [1:0]            w_lane;
    logic [4:0]            w_shamt;
    logic [3:0]            w_be;
    logic [ADDR_WIDTH-1:0] w_r_addr;
    logic [DATA_WIDTH-1:0] w_shifted;
    logic [DATA_WIDTH-1:0] w_load_data;

    // Grant: I wins when alone or when D took the last grant; nothing is granted in reset
    always_comb begin
        w_gnt_i = rst & bus.i_valid & (~bus.d_valid | r_last_d);
        w_gnt_d = rst & bus.d_valid & ~w_gnt_i;
    end

    // Alignment / size checks; erroring requests are accepted but never reach the memory
    always_comb begin
        w_i_err   = |bus.i_addr[1:0];
        w_d_err   = (bus.d_size == 2'b11) |
                    ((bus.d_size == 2'b01) & bus.d_addr[0]) |
                    ((bus.d_size == 2'b10) & (|bus.d_addr[1:0]));
        w_d_load  = w_gnt_d & ~bus.d_we & ~w_d_err;
        w_d_store = w_gnt_d & bus.d_we & ~w_d_err;
    end

    // Lane steering: byte enables and store data move into the addressed lane, load data moves out of it
    always_comb begin
        w_lane      = bus.d_addr[1:0];
        w_shamt     = {w_lane, 3'b000};
        w_be        = (bus.d_size == 2'b00) ? (4'b0001 << w_lane) :
                      (bus.d_size == 2'b01) ? (4'b0011 << w_lane) : 4'b1111;
        w_r_addr    = w_gnt_i ? bus.i_addr : bus.d_addr;
        w_shifted   = bus.mem_r_dat >> w_shamt;
        w_load_data = (bus.d_size == 2'b00) ? {{(DATA_WIDTH-8){~bus.d_unsigned & w_shifted[7]}}, w_shifted[7:0]} :
                      (bus.d_size == 2'b01) ? {{(DATA_WIDTH-16){~bus.d_unsigned & w_shifted[15]}}, w_shifted[15:0]} :
                      w_shifted;
    end

    assign bus.i_ready      = w_gnt_i;
    assign bus.d_ready      = w_gnt_d;
    assign bus.mem_r_enb    = (w_gnt_i & ~w_i_err) | w_d_load;
    assign bus.mem_r_addr   = w_r_addr;
    assign bus.mem_w_enb    = w_d_store;
    assign bus.mem_w_addr   = bus.d_addr;
    assign bus.mem_w_dat    = bus.d_wdata << w_shamt;
    assign bus.mem_byte_enb = w_d_store ? w_be : 4'b0000;
    assign bus.i_rvalid     = r_i_rvalid;
    assign bus.i_err        = r_i_err;
    assign bus.i_rdata      = r_i_rdata;
    assign bus.d_rvalid     = r_d_rvalid;
    assign bus.d_err        = r_d_err;
    assign bus.d_rdata      = r_d_rdata;

    // Round-robin pointer: remembers whether D took the last grant; reset lets I win first
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_last_d <= 1'b1;
        else if (w_gnt_i | w_gnt_d)
            r_last_d <= w_gnt_d;
    end

    // Responses: one-cycle pulse after each accept; reset drops anything in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_i_rvalid <= 1'b0;
            r_i_err    <= 1'b0;
            r_i_rdata  <= '0;
            r_d_rvalid <= 1'b0;
            r_d_err    <= 1'b0;
            r_d_rdata  <= '0;
        end else begin
            r_i_rvalid <= w_gnt_i;
            r_i_err    <= w_gnt_i & w_i_err;
            r_i_rdata  <= (w_gnt_i & ~w_i_err) ? bus.mem_r_dat : '0;
            r_d_rvalid <= w_gnt_d;
            r_d_err    <= w_gnt_d & w_d_err;
            r_d_rdata  <= w_d_load ? w_load_data : '0;
        end
    end
endmodule

// File: tb/tb_bram32_arbiter.sv
// tb_bram32_arbiter: directed and random checks of bram32_arbiter against a byte-level memory model
module tb_bram32_arbiter;
    localparam int AW = 12;

    logic clk = 1'b0;
    logic rst = 1'b0;

    bram32_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus ();

    bram32_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    bit [7:0] bram [4096];

    assign bus.mem_r_dat = {bram[{bus.mem_r_addr[AW-1:2], 2'd3}], bram[{bus.mem_r_addr[AW-1:2], 2'd2}],
                            bram[{bus.mem_r_addr[AW-1:2], 2'd1}], bram[{bus.mem_r_addr[AW-1:2], 2'd0}]};

    // bram32 stand-in: byte-enabled write committing at the clock edge
    always @(posedge clk)
        if (bus.mem_w_enb)
            for (int k = 0; k < 4; k++)
                if (bus.mem_byte_enb[k])
                    bram[{bus.mem_w_addr[AW-1:2], k[1:0]}] <= bus.mem_w_dat[8*k+:8];

    bit [7:0]    ref_mem [4096];
    bit          last_d = 1'b1;
    bit          g_i, g_d;
    bit          p_irv, p_ierr, p_drv, p_derr, c_ird, c_drd;
    logic [31:0] p_ird, p_drd;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit [2:0]    seq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit iv, input logic [AW-1:0] ia, input bit dv, input bit we,
                         input logic [1:0] sz, input bit un, input logic [AW-1:0] da, input logic [31:0] wd);
        bus.i_valid    = iv;
        bus.i_addr     = ia;
        bus.d_valid    = dv;
        bus.d_we       = we;
        bus.d_size     = sz;
        bus.d_unsigned = un;
        bus.d_addr     = da;
        bus.d_wdata    = wd;
    endtask

    task automatic step();
        bit ei, ed, ld, st;
        int n, a, ia;
        logic [31:0] vi, vd, ew, m;
        logic [3:0] be;
        @(negedge clk);
        g_i = bus.i_valid && (!bus.d_valid || last_d);
        g_d = bus.d_valid && !g_i;
        chk("i_ready", bus.i_ready, g_i);
        chk("d_ready", bus.d_ready, g_d);
        a  = int'(bus.d_addr);
        ia = int'(bus.i_addr);
        ei = (ia % 4) != 0;
        ed = bus.d_size == 2'd3 || (bus.d_size == 2'd1 && (a % 2) != 0) || (bus.d_size == 2'd2 && (a % 4) != 0);
        n  = 1 << bus.d_size;
        ld = g_d && !bus.d_we && !ed;
        st = g_d && bus.d_we && !ed;
        chk("r_enb", bus.mem_r_enb, (g_i && !ei) || ld);
        chk("w_enb", bus.mem_w_enb, st);
        chk("enb_excl", bus.mem_r_enb & bus.mem_w_enb, 0);
        vi = '0;
        if (g_i && !ei) begin
            chk("r_addr_i", bus.mem_r_addr, bus.i_addr);
            for (int k = 0; k < 4; k++) vi[8*k+:8] = ref_mem[ia+k];
        end
        vd = '0;
        if (ld) begin
            chk("r_addr_d", bus.mem_r_addr, bus.d_addr);
            for (int k = 0; k < n; k++) vd[8*k+:8] = ref_mem[a+k];
            if (!bus.d_unsigned && n < 4 && vd[8*n-1]) vd = vd | (32'hFFFFFFFF << (8*n));
        end
        if (st) begin
            be = '0;
            ew = '0;
            m  = '0;
            for (int k = 0; k < n; k++) begin
                be[(a % 4) + k]          = 1'b1;
                ew[8*((a % 4) + k)+:8]   = bus.d_wdata[8*k+:8];
                m[8*((a % 4) + k)+:8]    = 8'hFF;
                ref_mem[a+k]             = bus.d_wdata[8*k+:8];
            end
            chk("w_addr", bus.mem_w_addr, bus.d_addr);
            chk("byte_enb", bus.mem_byte_enb, be);
            chk("w_dat", bus.mem_w_dat & m, ew);
        end
        p_irv  = g_i;
        p_ierr = g_i && ei;
        p_ird  = vi;
        c_ird  = g_i && !ei;
        p_drv  = g_d;
        p_derr = g_d && ed;
        p_drd  = vd;
        c_drd  = g_d && !ed;
        if (g_i) last_d = 1'b0;
        else if (g_d) last_d = 1'b1;
        @(posedge clk);
        #1;
        chk("i_rvalid", bus.i_rvalid, p_irv);
        chk("i_err", bus.i_err, p_ierr);
        if (c_ird) chk("i_rdata", bus.i_rdata, p_ird);
        chk("d_rvalid", bus.d_rvalid, p_drv);
        chk("d_err", bus.d_err, p_derr);
        if (c_drd) chk("d_rdata", bus.d_rdata, p_drd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        drive(1, 12'h010, 1, 1, 2'd2, 0, 12'h020, 32'h12345678);
        #12;
        chk("rst_r_enb", bus.mem_r_enb, 0);
        chk("rst_w_enb", bus.mem_w_enb, 0);
        chk("rst_i_rvalid", bus.i_rvalid, 0);
        chk("rst_d_rvalid", bus.d_rvalid, 0);
        chk("rst_i_rdata", bus.i_rdata, 0);
        chk("rst_d_rdata", bus.d_rdata, 0);
        chk("rst_errs", {bus.i_err, bus.d_err}, 0);
        drive(0, 12'h000, 0, 0, 2'd0, 0, 12'h000, 32'h0);
        rst = 1'b1;
        step();
        chk("idle_i_rdata", bus.i_rdata, 0);
        chk("idle_d_rdata", bus.d_rdata, 0);
        drive(0, 12'h000, 1, 1, 2'd2, 0, 12'h010, 32'hDEADBEEF);
        step();
        drive(1, 12'h010, 0, 0, 2'd0, 0, 12'h000, 32'h0);
        step();
        chk("fetch_word", bus.i_rdata, 32'hDEADBEEF);
        drive(0, 12'h000, 1, 1, 2'd0, 0, 12'h103, 32'h000000A5);
        step();
        drive(0, 12'h000, 1, 0, 2'd0, 0, 12'h103, 32'h0);
        step();
        chk("lb_signed", bus.d_rdata, 32'hFFFFFFA5);
        drive(0, 12'h000, 1, 0, 2'd0, 1, 12'h103, 32'h0);
        step();
        chk("lb_unsigned", bus.d_rdata, 32'h000000A5);
        drive(1, 12'h010, 1, 0, 2'd2, 0, 12'h010, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            seq[k] = g_d;
        end
        chk("rr_seq", {29'd0, seq}, 32'd2);
        drive(0, 12'h000, 1, 0, 2'd1, 0, 12'h101, 32'h0);
        step();
        drive(0, 12'h000, 1, 0, 2'd3, 0, 12'h100, 32'h0);
        step();
        drive(0, 12'h000, 1, 1, 2'd2, 0, 12'h102, 32'hCAFEF00D);
        step();
        drive(1, 12'h012, 0, 0, 2'd0, 0, 12'h000, 32'h0);
        step();
        drive(0, 12'h000, 1, 0, 2'd2, 0, 12'h010, 32'h0);
        #2 rst = 1'b0;
        #2;
        chk("rstp_r_enb", bus.mem_r_enb, 0);
        chk("rstp_w_enb", bus.mem_w_enb, 0);
        @(posedge clk);
        #1;
        chk("rstp_d_rvalid", bus.d_rvalid, 0);
        chk("rstp_d_rdata", bus.d_rdata, 0);
        last_d = 1'b1;
        g_i = 1'b0;
        g_d = 1'b0;
        drive(0, 12'h000, 0, 0, 2'd0, 0, 12'h000, 32'h0);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_d_rvalid", bus.d_rvalid, 0);
        drive(0, 12'h000, 1, 0, 2'd2, 0, 12'h010, 32'h0);
        step();
        chk("post_rst_load", bus.d_rdata, 32'hDEADBEEF);
        for (int c = 0; c < 400; c++) begin
            if (!(bus.i_valid && !g_i)) begin
                bus.i_valid = ($urandom_range(0, 2) != 0);
                bus.i_addr  = AW'(32'h100 + $urandom_range(0, 63));
                if ($urandom_range(0, 7) != 0) bus.i_addr[1:0] = 2'b00;
            end
            if (!(bus.d_valid && !g_d)) begin
                bus.d_valid    = ($urandom_range(0, 2) != 0);
                bus.d_we       = 1'($urandom_range(0, 1));
                bus.d_size     = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                bus.d_unsigned = 1'($urandom_range(0, 1));
                bus.d_addr     = AW'(32'h100 + $urandom_range(0, 63));
                if ($urandom_range(0, 7) != 0) begin
                    if (bus.d_size == 2'd1) bus.d_addr[0] = 1'b0;
                    else if (bus.d_size == 2'd2) bus.d_addr[1:0] = 2'b00;
                end
                bus.d_wdata = $urandom;
            end
            step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
